// File: rtl/seg_reg_bank.sv
// Pipeline segment register bank: NCH channels of WIDTH bits plus valid, with
// bubble (hold) and flush (squash) control and saturating stall/flush counters.

// Saturating event counter: counts inc pulses, sticks at all-ones, clr wins.
module seg_evt_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    typedef enum logic {
        CNT_RUN = 1'b0,
        CNT_SAT = 1'b1
    } cnt_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    cnt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CNT_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = CNT_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CNT_RUN: begin
                    if (inc) begin
                        cnt_d = cnt_q + CNT_ONE;
                        // Reaching all-ones parks the counter until cleared.
                        if (cnt_q == CNT_LAST) begin
                            state_d = CNT_SAT;
                        end
                    end
                end
                CNT_SAT: begin
                    state_d = CNT_SAT;
                end
                default: begin
                    state_d = CNT_RUN;
                end
            endcase
        end
    end

    assign cnt = cnt_q;

endmodule

module seg_reg_bank #(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       NCH       = 4,
    parameter logic [WIDTH-1:0]  FLUSH_VAL = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bubble,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic                 cnt_clr,
    output logic [NCH*WIDTH-1:0] q,
    output logic                 valid_out,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic valid_q, valid_d;
    logic flush_eff;

    // A flush under bubble is dropped entirely, so it neither loads nor counts.
    assign flush_eff = !bubble && flush;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] ch_q, ch_d;

            always_comb begin
                ch_d = ch_q;
                if (!bubble) begin
                    ch_d = flush ? FLUSH_VAL : d[gi*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ch_q <= FLUSH_VAL;
                end else begin
                    ch_q <= ch_d;
                end
            end

            assign q[gi*WIDTH +: WIDTH] = ch_q;
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        if (!bubble) begin
            valid_d = flush ? 1'b0 : valid_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid_out = valid_q;

    seg_evt_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bubble),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

    seg_evt_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_eff),
        .clr (cnt_clr),
        .cnt (flush_cnt)
    );

endmodule
